stream_arb_2to1: RTL and testbench

- Two-channel round-robin stream arbiter with packet lock; it generates the select and muxes two valid/ready streams onto one registered output stream.
- Sits directly upstream of the 2:1 selection datapath and the consumers behind it, so `mux_2to1` never sees a select change mid-packet.
- One output register stage, sustaining one beat per cycle.

---
 rtl/stream_arb_pkg.sv | 17 +
 rtl/rr_grant_2.sv | 32 +++
 rtl/stream_arb_2to1.sv | 119 +++++++++++
 tb/tb_stream_arb_2to1.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/stream_arb_pkg.sv
// Shared types for the 2:1 packet-locking stream arbiter: FSM states and channel indices.
package stream_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_e;

  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;

  function automatic arb_state_e lock_state(input logic ch);
    return ch ? LOCK1 : LOCK0;
  endfunction

endpackage

// File: rtl/rr_grant_2.sv
// Combinational 2-way round-robin grant; a LOCK state pins the grant to its owner.
// Zero latency, no storage; the grant index stays defined (CH0) when nothing is granted.
module rr_grant_2
  import stream_arb_pkg::*;
(
  input  logic [1:0] req_i,
  input  logic       prio_i,
  input  logic [1:0] state_i,
  output logic       grant_o,
  output logic       grant_vld_o
);

  always_comb begin
    grant_o     = CH0;
    grant_vld_o = 1'b0;
    case (state_i)
      LOCK0: begin
        grant_o     = CH0;
        grant_vld_o = 1'b1;
      end
      LOCK1: begin
        grant_o     = CH1;
        grant_vld_o = 1'b1;
      end
      default: begin
        grant_vld_o = |req_i;
        grant_o     = (req_i == 2'b11) ? prio_i : req_i[1];
      end
    endcase
  end

endmodule

// File: rtl/stream_arb_2to1.sv
// Round-robin 2:1 stream arbiter with packet lock feeding one registered output stage.
// One cycle input-to-output; input ready follows load = ~out_valid | out_ready, no skid buffer.
module stream_arb_2to1
  import stream_arb_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter bit LOCK_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in0_valid,
  input  logic [DATA_W-1:0] in0_data,
  input  logic              in0_last,
  output logic              in0_ready,
  input  logic              in1_valid,
  input  logic [DATA_W-1:0] in1_data,
  input  logic              in1_last,
  output logic              in1_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              out_src,
  input  logic              out_ready,
  output logic              busy
);

  arb_state_e        state_q, state_d;
  logic              prio_q, prio_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic              out_src_q, out_src_d;

  logic              grant, grant_vld;
  logic              load, acc, acc_last;
  logic [DATA_W-1:0] acc_data;

  rr_grant_2 u_grant (
    .req_i       ({in1_valid, in0_valid}),
    .prio_i      (prio_q),
    .state_i     (state_q),
    .grant_o     (grant),
    .grant_vld_o (grant_vld)
  );

  assign load = ~out_valid_q | out_ready;

  // In IDLE grant_vld already implies the granted channel is valid; in LOCK ready is offered unconditionally.
  assign in0_ready = rst_n & load & grant_vld & (grant == CH0);
  assign in1_ready = rst_n & load & grant_vld & (grant == CH1);

  assign acc      = (in0_valid & in0_ready) | (in1_valid & in1_ready);
  assign acc_data = (grant == CH1) ? in1_data : in0_data;
  assign acc_last = LOCK_EN ? ((grant == CH1) ? in1_last : in0_last) : 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (acc) begin
      state_d = acc_last ? IDLE : lock_state(grant);
    end
  end

  always_comb begin
    busy = (state_q != IDLE);
  end

  // A completed packet hands preference to the other channel, even with no contention.
  always_comb begin
    prio_d = prio_q;
    if (acc && acc_last) begin
      prio_d = ~grant;
    end
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_last_d  = out_last_q;
    out_src_d   = out_src_q;
    if (load) begin
      out_valid_d = acc;
      if (acc) begin
        out_data_d = acc_data;
        out_last_d = acc_last;
        out_src_d  = grant;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prio_q      <= CH0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_last_q  <= 1'b0;
      out_src_q   <= CH0;
    end else begin
      prio_q      <= prio_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_last_q  <= out_last_d;
      out_src_q   <= out_src_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_last  = out_last_q;
  assign out_src   = out_src_q;

endmodule

// File: tb/tb_stream_arb_2to1.sv
// Random traffic into a locking and a non-locking arbiter, checked by a packet-level model and scoreboard.
module tb_stream_arb_2to1;

  typedef struct packed {
    logic [7:0] d;
    logic       l;
    logic       s;
  } beat_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       vld [2][2];
  logic [7:0] dat [2][2];
  logic       lst [2][2];
  logic       rdy [2][2];
  logic       out_rdy [2];
  logic       out_vld [2];
  logic [7:0] out_dat [2];
  logic       out_lst [2];
  logic       out_src [2];
  logic       busy [2];

  int    n_vec = 0;
  int    n_err = 0;
  bit    chk_en = 1'b0;
  int    owner [2];
  bit    pref [2];
  bit    full [2];
  bit    hs [2][2];
  beat_t q0 [$];
  beat_t q1 [$];

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    stream_arb_2to1 #(.DATA_W(8), .LOCK_EN(gi == 0)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in0_valid (vld[gi][0]),
      .in0_data  (dat[gi][0]),
      .in0_last  (lst[gi][0]),
      .in0_ready (rdy[gi][0]),
      .in1_valid (vld[gi][1]),
      .in1_data  (dat[gi][1]),
      .in1_last  (lst[gi][1]),
      .in1_ready (rdy[gi][1]),
      .out_valid (out_vld[gi]),
      .out_data  (out_dat[gi]),
      .out_last  (out_lst[gi]),
      .out_src   (out_src[gi]),
      .out_ready (out_rdy[gi]),
      .busy      (busy[gi])
    );
  end

  function automatic void q_push(int i, beat_t b);
    if (i == 0) q0.push_back(b); else q1.push_back(b);
  endfunction

  function automatic int q_size(int i);
    return (i == 0) ? q0.size() : q1.size();
  endfunction

  function automatic beat_t q_front(int i);
    return (i == 0) ? q0[0] : q1[0];
  endfunction

  function automatic void q_pop(int i);
    if (i == 0) void'(q0.pop_front()); else void'(q1.pop_front());
  endfunction

  task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s inst%0d @%0t: got %0h expected %0h", nm, inst, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      owner[i] = -1;
      pref[i]  = 1'b0;
      full[i]  = 1'b0;
      hs[i][0] = 1'b0;
      hs[i][1] = 1'b0;
    end
    q0.delete();
    q1.delete();
  endtask

  // Packet-level reference: the owner of an open packet keeps the port, otherwise the
  // preferred channel wins contention; a finished packet passes preference to the other side.
  initial forever begin
    @(negedge clk);
    if (chk_en && rst_n) begin
      for (int i = 0; i < 2; i++) begin
        bit load;
        bit exp0, exp1, last_eff;
        int g, a;
        load = !full[i] || out_rdy[i];
        if (owner[i] >= 0)              g = owner[i];
        else if (vld[i][0] && vld[i][1]) g = pref[i] ? 1 : 0;
        else if (vld[i][0])             g = 0;
        else if (vld[i][1])             g = 1;
        else                            g = -1;
        exp0 = load && (g == 0);
        exp1 = load && (g == 1);
        chk("in0_ready", i, rdy[i][0], exp0);
        chk("in1_ready", i, rdy[i][1], exp1);
        chk("busy", i, busy[i], owner[i] >= 0);
        chk("out_valid", i, out_vld[i], full[i]);
        a = -1;
        if (exp0 && vld[i][0]) a = 0;
        else if (exp1 && vld[i][1]) a = 1;
        if (a >= 0) begin
          last_eff = (i == 0) ? lst[i][a] : 1'b1;
          q_push(i, '{d: dat[i][a], l: last_eff, s: a[0]});
          if (last_eff) begin
            owner[i] = -1;
            pref[i]  = (a == 0);
          end else begin
            owner[i] = a;
          end
        end
        if (load) full[i] = (a >= 0);
      end
    end
  end

  // Whatever sits on the output must be the oldest outstanding beat; it leaves on out_ready.
  initial forever begin
    @(negedge clk);
    if (chk_en && rst_n) begin
      for (int i = 0; i < 2; i++) begin
        if (out_vld[i]) begin
          if (q_size(i) == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL out_unexpected inst%0d @%0t: got beat %0h, scoreboard empty", i, $time, out_dat[i]);
          end else begin
            beat_t e;
            e = q_front(i);
            chk("out_data", i, out_dat[i], e.d);
            chk("out_last", i, out_lst[i], e.l);
            chk("out_src", i, out_src[i], e.s);
            if (out_rdy[i]) q_pop(i);
          end
        end
      end
    end
  end

  task automatic step_to_posedge();
    @(negedge clk);
    for (int i = 0; i < 2; i++)
      for (int c = 0; c < 2; c++)
        hs[i][c] = vld[i][c] && rdy[i][c];
    @(posedge clk);
  endtask

  task automatic drive();
    #1;
    for (int i = 0; i < 2; i++) begin
      for (int c = 0; c < 2; c++) begin
        if (hs[i][c] || !vld[i][c]) begin
          if ($urandom_range(0, 9) < 8) begin
            vld[i][c] = 1'b1;
            dat[i][c] = 8'($urandom);
            lst[i][c] = ($urandom_range(0, 2) == 0);
          end else begin
            vld[i][c] = 1'b0;
          end
        end
      end
      out_rdy[i] = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic run_cycles(input int n);
    repeat (n) begin
      step_to_posedge();
      drive();
    end
  endtask

  initial begin
    bit found;
    rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < 2; i++) begin
      out_rdy[i] = 1'b1;
      for (int c = 0; c < 2; c++) begin
        vld[i][c] = 1'b1;
        dat[i][c] = 8'($urandom);
        lst[i][c] = 1'b1;
      end
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      chk("rst_in0_ready", i, rdy[i][0], 0);
      chk("rst_in1_ready", i, rdy[i][1], 0);
      chk("rst_out_valid", i, out_vld[i], 0);
      chk("rst_out_src", i, out_src[i], 0);
      chk("rst_out_data", i, out_dat[i], 0);
      chk("rst_busy", i, busy[i], 0);
    end
    @(posedge clk);
    #3;
    rst_n  = 1'b1;
    chk_en = 1'b1;
    run_cycles(2500);

    found = 1'b0;
    for (int k = 0; k < 5000 && !found; k++) begin
      step_to_posedge();
      if (owner[0] == 1) found = 1'b1;
      else drive();
    end
    if (!found) begin
      n_vec++;
      n_err++;
      $display("FAIL lock1_reach inst0: got no LOCK1 within 5000 cycles, required one");
    end else begin
      #3;
      chk_en = 1'b0;
      rst_n  = 1'b0;
      #1;
      for (int i = 0; i < 2; i++) begin
        chk("arst_out_valid", i, out_vld[i], 0);
        chk("arst_out_data", i, out_dat[i], 0);
        chk("arst_out_last", i, out_lst[i], 0);
        chk("arst_out_src", i, out_src[i], 0);
        chk("arst_busy", i, busy[i], 0);
        chk("arst_in0_ready", i, rdy[i][0], 0);
        chk("arst_in1_ready", i, rdy[i][1], 0);
      end
    end
    model_reset();
    rst_n = 1'b0;
    for (int c = 0; c < 2; c++) begin
      vld[0][c] = 1'b1;
      dat[0][c] = 8'($urandom);
      lst[0][c] = 1'b0;
      vld[1][c] = 1'b0;
    end
    out_rdy[0] = 1'b1;
    out_rdy[1] = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    rst_n  = 1'b1;
    chk_en = 1'b1;
    run_cycles(1500);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
